// File: rtl/alu_stage.sv
// Registered ALU stage between the UART receiver and transmitter: latches a command,
// computes result and flags, strobes the transmitter and waits for its completion tick.
module alu_stage #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_operation,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_busy,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_op_error,
  output logic               o_overrun
);

  localparam int unsigned MSB = NB_DATA - 1;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ISSUE,
    S_WAIT_TX
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_b;
  logic [NB_OP-1:0]   r_op;

  logic [NB_DATA:0]   w_sum;
  logic [NB_DATA:0]   w_diff;
  logic [NB_DATA-1:0] w_result;
  logic               w_carry;
  logic               w_overflow;
  logic               w_op_error;

  logic [NB_DATA-1:0] r_result;
  logic               r_result_valid;
  logic               r_busy;
  logic               r_zero;
  logic               r_carry;
  logic               r_overflow;
  logic               r_op_error;
  logic               r_overrun;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (i_valid) w_next_state = S_EXEC;
      S_EXEC:    w_next_state = S_ISSUE;
      S_ISSUE:   w_next_state = S_WAIT_TX;
      S_WAIT_TX: if (i_tx_done) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Command capture: only an idle stage accepts a new frame
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (r_state == S_IDLE && i_valid) begin
      r_a  <= i_data_a;
      r_b  <= i_data_b;
      r_op <= i_operation;
    end
  end

  // Extra top bit holds ADD carry-out and SUB borrow
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    w_op_error = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_result   = w_sum[MSB:0];
        w_carry    = w_sum[NB_DATA];
        w_overflow = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUB: begin
        w_result   = w_diff[MSB:0];
        w_carry    = w_diff[NB_DATA];
        w_overflow = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      OP_AND:  w_result = r_a & r_b;
      OP_OR:   w_result = r_a | r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_NOR:  w_result = ~(r_a | r_b);
      OP_SRL:  w_result = r_a >> r_b;
      OP_SRA:  w_result = NB_DATA'($signed(r_a) >>> r_b);
      default: w_op_error = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_zero         <= 1'b0;
      r_carry        <= 1'b0;
      r_overflow     <= 1'b0;
      r_op_error     <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_result_valid <= (w_next_state == S_ISSUE);
      r_busy         <= (w_next_state != S_IDLE);
      if (r_state == S_EXEC) begin
        r_result   <= w_result;
        r_zero     <= (w_result == '0);
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
        r_op_error <= w_op_error;
      end
      if (i_valid && r_state != S_IDLE) r_overrun <= 1'b1;
    end
  end

  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = r_busy;
  assign o_zero         = r_zero;
  assign o_carry        = r_carry;
  assign o_overflow     = r_overflow;
  assign o_op_error     = r_op_error;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_alu_stage.sv
// Bench for alu_stage: directed scenarios then randomized commands checked against an
// arithmetic reference model; outputs are sampled on the falling clock edge.
module tb_alu_stage;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data_a = '0;
  logic [7:0] i_data_b = '0;
  logic [5:0] i_operation = '0;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_result;
  logic       o_result_valid, o_busy, o_zero, o_carry, o_overflow, o_op_error, o_overrun;

  int checks = 0;
  int failures = 0;
  logic exp_overrun = 1'b0;
  logic [7:0] last_result = '0;

  alu_stage #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_operation(i_operation),
    .i_tx_done(i_tx_done), .o_result(o_result), .o_result_valid(o_result_valid),
    .o_busy(o_busy), .o_zero(o_zero), .o_carry(o_carry), .o_overflow(o_overflow),
    .o_op_error(o_op_error), .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic on the operand values
  function automatic void model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic z, output logic c,
                                output logic v, output logic e);
    int ua, ub, sa, sb, t;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = 8'h00; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      6'b100000: begin
        t = ua + ub; r = 8'(t); c = (t > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      6'b100010: begin
        t = ua - ub; r = 8'(t); c = (ua < ub);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b000010: r = (ub >= 8) ? 8'h00 : 8'(ua / (1 << ub));
      6'b000011: begin
        t = (ub >= 8) ? 7 : ub;
        r = 8'(sa >>> t);
      end
      default: e = 1'b1;
    endcase
    z = (r == 8'h00);
  endfunction

  // Drives one command and checks EXEC, ISSUE and first WAIT_TX cycles; returns in WAIT_TX
  task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic z, c, v, e;
    model(op, a, b, r, z, c, v, e);
    @(negedge i_clock);
    i_valid = 1'b1; i_operation = op; i_data_a = a; i_data_b = b;
    @(negedge i_clock);
    i_valid = 1'b0;
    chk("exec_busy", o_busy, 1);
    chk("exec_rv", o_result_valid, 0);
    @(negedge i_clock);
    chk("issue_rv", o_result_valid, 1);
    chk("issue_result", o_result, r);
    chk("issue_flags", {o_zero, o_carry, o_overflow, o_op_error}, {z, c, v, e});
    chk("issue_overrun", o_overrun, exp_overrun);
    chk("issue_busy", o_busy, 1);
    last_result = r;
    @(negedge i_clock);
    chk("wait_rv", o_result_valid, 0);
    chk("wait_busy", o_busy, 1);
  endtask

  task automatic finish_tx();
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_tx_done = 1'b0;
    chk("done_busy", o_busy, 0);
    chk("done_result_hold", o_result, last_result);
  endtask

  logic [5:0] legal_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b000010, 6'b000011};

  initial begin
    // Reset state
    repeat (3) @(negedge i_clock);
    chk("rst_outputs", {o_result, o_result_valid, o_busy, o_zero, o_carry, o_overflow,
                        o_op_error, o_overrun}, 0);
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("idle_busy", o_busy, 0);

    // Directed arithmetic cases
    issue(6'b100000, 8'h7F, 8'h01);
    chk("tp_add_result", o_result, 8'h80);
    chk("tp_add_ovf", o_overflow, 1);
    finish_tx();
    issue(6'b100010, 8'h05, 8'h05);
    chk("tp_sub_zero", o_zero, 1);
    finish_tx();
    issue(6'b100010, 8'h03, 8'h05);
    chk("tp_sub_borrow", {o_result, o_carry, o_overflow}, {8'hFE, 1'b1, 1'b0});
    finish_tx();
    issue(6'b000011, 8'h80, 8'd3);
    chk("tp_sra", o_result, 8'hF0);
    finish_tx();
    issue(6'b000010, 8'h80, 8'd9);
    chk("tp_srl_big", o_result, 8'h00);
    finish_tx();
    issue(6'b100111, 8'hF0, 8'h0F);
    chk("tp_nor_zero", {o_result, o_zero}, {8'h00, 1'b1});
    finish_tx();

    // Illegal opcode still issues; next legal op clears the error
    issue(6'b111111, 8'h12, 8'h34);
    chk("tp_illegal", {o_result, o_op_error}, {8'h00, 1'b1});
    finish_tx();
    issue(6'b100000, 8'h01, 8'h01);
    chk("tp_add_after_err", {o_result, o_op_error}, {8'h02, 1'b0});

    // Command during WAIT_TX is dropped and flags overrun
    i_valid = 1'b1; i_operation = 6'b100100; i_data_a = 8'hFF; i_data_b = 8'h0F;
    @(negedge i_clock);
    i_valid = 1'b0;
    exp_overrun = 1'b1;
    chk("ovr_set", o_overrun, 1);
    chk("ovr_result_kept", o_result, 8'h02);
    chk("ovr_still_busy", o_busy, 1);
    finish_tx();
    issue(6'b100100, 8'hFF, 8'h0F);
    chk("ovr_and_result", {o_result, o_overrun}, {8'h0F, 1'b1});

    // i_valid together with i_tx_done: back to IDLE, command dropped
    i_valid = 1'b1; i_tx_done = 1'b1;
    @(negedge i_clock);
    i_valid = 1'b0; i_tx_done = 1'b0;
    chk("combo_busy", o_busy, 0);
    @(negedge i_clock);
    chk("combo_dropped", {o_busy, o_result_valid}, 0);

    // i_tx_done while idle is ignored
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_tx_done = 1'b0;
    chk("idle_txdone_ignored", {o_busy, o_result_valid}, 0);

    // Reset in WAIT_TX abandons the result
    issue(6'b100101, 8'hA0, 8'h05);
    #1 i_reset = 1'b1;
    #1;
    chk("rst_async_outputs", {o_result, o_result_valid, o_busy, o_zero, o_carry, o_overflow,
                              o_op_error, o_overrun}, 0);
    exp_overrun = 1'b0;
    last_result = 8'h00;
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clock);
      chk("post_rst_quiet", {o_busy, o_result_valid}, 0);
    end
    issue(6'b100110, 8'h3C, 8'h0F);
    chk("post_rst_xor", o_result, 8'h33);
    finish_tx();

    // Randomized commands with random transmitter latency and stray commands
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic [7:0] a, b;
      int waits;
      op = legal_ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      issue(op, a, b);
      waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) begin
        i_valid = ($urandom_range(0, 4) == 0);
        i_data_a = 8'($urandom);
        if (i_valid) exp_overrun = 1'b1;
        @(negedge i_clock);
        i_valid = 1'b0;
        chk("rnd_wait", {o_busy, o_result_valid, o_result, o_overrun},
            {1'b1, 1'b0, last_result, exp_overrun});
      end
      finish_tx();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
# alu_stage

Registered ALU stage directly downstream of the UART receive path. It captures operands A and B and a 6-bit opcode when the UART command interface signals a complete frame, and computes a registered result with status flags. It then issues a one-cycle start strobe to the UART transmitter and holds further commands until the transmitter reports completion. Its result and strobe feed the transmitter's data and start inputs.

## Interface
- NB_DATA, 8, operand/result width
- NB_OP, 6, opcode width
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  one-cycle pulse: i_data_a/i_data_b/i_operation complete and stable
- i_data_a  in  NB_DATA  operand A
- i_data_b  in  NB_DATA  operand B (shift amount for shifts)
- i_operation  in  NB_OP  opcode
- i_tx_done  in  1  one-cycle tick from transmitter: byte sent
- o_result  out  NB_DATA  registered result
- o_result_valid  out  1  one-cycle pulse, transmitter start
- o_busy  out  1  high in every state except IDLE
- o_zero  out  1  result == 0
- o_carry  out  1  ADD carry-out / SUB borrow
- o_overflow  out  1  signed overflow (ADD/SUB)
- o_op_error  out  1  last opcode illegal
- o_overrun  out  1  sticky: i_valid arrived while busy

## Operation
- FSM states: IDLE, EXEC, ISSUE, WAIT_TX.
- IDLE: i_valid=1 latches A, B and op into internal registers, then goes to EXEC. i_valid=0 stays in IDLE.
- EXEC: computes from the latched operands and registers o_result and all flags, then goes to ISSUE.
- ISSUE: o_result_valid=1 for exactly this cycle, then goes to WAIT_TX.
- WAIT_TX: waits for i_tx_done=1, then goes to IDLE. There is no timeout.
- i_tx_done outside WAIT_TX is ignored.
- i_valid outside IDLE: command dropped, o_overrun set to 1. o_overrun clears only on reset.
- Opcodes:
  - ADD 6'b100000: A+B
  - SUB 6'b100010: A−B
  - AND 6'b100100
  - OR 6'b100101
  - XOR 6'b100110
  - NOR 6'b100111
  - SRL 6'b000010: A>>B, zero fill
  - SRA 6'b000011: A>>>B, sign fill
- Arithmetic is NB_DATA wide and wraps modulo 2^NB_DATA.
- Carry rules:
  - ADD: carry = bit NB_DATA of the (NB_DATA+1)-bit sum.
  - SUB: carry = 1 iff A<B unsigned.
  - All other ops: carry = 0.
- Overflow rules:
  - ADD: 1 iff A and B have equal sign bits and the result sign differs.
  - SUB: 1 iff A and B have different sign bits and the result sign differs from A.
  - All other ops: overflow = 0.
- Shifts use the full B value.
  - B ≥ NB_DATA gives all zeros for SRL and all copies of A's MSB for SRA.
  - B=0 gives A.
- Illegal opcode: o_result=0, o_zero=1, o_carry=0, o_overflow=0, o_op_error=1. The response is still issued (ISSUE/WAIT_TX).
- Legal opcode: o_op_error=0.
- o_result and all flags hold their values from EXEC until the next EXEC.

## Timing
- i_valid sampled high in cycle N (IDLE):
  - Operands latched at edge N→N+1.
  - EXEC in N+1.
  - o_result/flags updated at edge N+1→N+2.
  - o_result_valid=1 in N+2. o_result is already stable in that cycle.
- o_busy=1 from N+1 until the cycle after i_tx_done is sampled in WAIT_TX.
- Minimum command spacing: the next i_valid is accepted in the cycle after WAIT_TX→IDLE.
- Reset values (all immediate, asynchronous):
  - State = IDLE.
  - o_result=0, o_result_valid=0, o_busy=0.
  - o_zero=0, o_carry=0, o_overflow=0, o_op_error=0, o_overrun=0.
  - Internal operand registers = 0.
- Reset in any state (including mid-WAIT_TX) abandons the pending result. No o_result_valid pulse follows reset release.
- i_valid and i_tx_done together in WAIT_TX: the FSM returns to IDLE, the i_valid is dropped and o_overrun is set.

## Test plan
- ADD A=0x7F, B=0x01, i_valid in cycle N -> o_result=0x80, o_overflow=1, o_carry=0, o_zero=0, o_result_valid pulses in N+2 only.
- SUB A=0x05, B=0x05 -> 0x00, o_zero=1, o_carry=0. Then SUB A=0x03, B=0x05 -> 0xFE, o_carry=1, o_overflow=0.
- SRA A=0x80, B=3 -> 0xF0. SRL A=0x80, B=9 -> 0x00. NOR A=0xF0, B=0x0F -> 0x00, o_zero=1.
- Opcode 6'b111111 -> o_result=0x00, o_op_error=1, o_result_valid still pulses. Next legal ADD 1+1 -> 0x02, o_op_error=0.
- i_valid (AND 0xFF, 0x0F) during WAIT_TX -> ignored, o_result unchanged, o_overrun=1. After i_tx_done, a new i_valid (AND) -> 0x0F and o_overrun still 1.
- Assert i_reset in WAIT_TX -> all outputs 0 immediately and no o_result_valid after release. A fresh command completes with normal N+2 latency.
